// File: rtl/mem_pkg.sv
// Shared definitions for the M-stage data-memory access unit.
package mem_pkg;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  localparam int unsigned ADDR_W_DEF  = 12;
  localparam int unsigned LATENCY_DEF = 2;

endpackage

// File: rtl/dm_ram.sv
// Word-addressed data memory: synchronous write, combinational read, synchronous clear.
module dm_ram #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [DEPTH];

  // NOTE: the array is cleared on reset because a load right after reset must read zero.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_access_unit.sv
// M-stage multi-cycle data-memory access: stalls the pipeline while an access is in flight
// and returns load data for the MEM/WB register.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite_M,
  input  logic        MemToReg_M,
  input  logic [31:0] ANS_M,
  input  logic [31:0] RD2_M,
  input  logic [31:0] PC_M,
  output logic        stall_M,
  output logic [31:0] RD_M,
  output logic        rd_valid,
  output logic        addr_err
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_access_unit: LATENCY must be within 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  ms_state_e         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       rd_q, rd_d;
  logic              store_q, store_d;
  logic              addr_err_q, addr_err_d;

  logic              req, ok, stall, ram_we;
  logic [31:0]       ram_rdata;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req        = MemWrite_M | MemToReg_M;
    ok         = (ANS_M[1:0] == 2'b00) && (ANS_M[31:ADDR_W+2] == '0);
    state_d    = state_q;
    cnt_d      = cnt_q;
    widx_d     = widx_q;
    data_d     = data_q;
    pc_d       = pc_q;
    rd_d       = rd_q;
    store_d    = store_q;
    addr_err_d = 1'b0;
    stall      = 1'b0;
    ram_we     = 1'b0;
    unique case (state_q)
      MS_IDLE: begin
        if (req) begin
          addr_err_d = !ok || (MemWrite_M && MemToReg_M);
          if (ok) begin
            widx_d  = ANS_M[ADDR_W+1:2];
            data_d  = RD2_M;
            pc_d    = PC_M;
            store_d = MemWrite_M;
            cnt_d   = CNT_INIT;
            state_d = MS_WAIT;
            stall   = 1'b1;
          end else begin
            rd_d = '0;
          end
        end
      end
      MS_WAIT: begin
        stall = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Commit uses only the latched request; live inputs are not looked at here.
          ram_we  = store_q;
          if (!store_q) rd_d = ram_rdata;
          state_d = MS_DONE;
        end
      end
      MS_DONE: state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= MS_IDLE;
      cnt_q      <= '0;
      widx_q     <= '0;
      data_q     <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
      store_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      widx_q     <= widx_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      store_q    <= store_d;
      addr_err_q <= addr_err_d;
    end
  end

  dm_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .clr_n (reset),
    .we    (ram_we),
    .addr  (widx_q),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && ram_we)
      $display("%d@%h: *%h <= %h", $time, pc_q, 32'({widx_q, 2'b00}), data_q);
  end
`endif

  // The pipeline must not be frozen while the block is being reset.
  assign stall_M  = reset & stall;
  assign RD_M     = rd_q;
  assign rd_valid = (state_q == MS_DONE) && !store_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus a randomized
// sequence checked against a word-array model of memory.
module tb_mem_access_unit;

  localparam int ADDR_W  = 12;
  localparam int LATENCY = 2;
  localparam int STALLS  = LATENCY + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite_M = 1'b0;
  logic        MemToReg_M = 1'b0;
  logic [31:0] ANS_M = '0;
  logic [31:0] RD2_M = '0;
  logic [31:0] PC_M = '0;
  logic        stall_M;
  logic [31:0] RD_M;
  logic        rd_valid;
  logic        addr_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [1 << ADDR_W];
  logic [31:0] ref_rd;

  mem_access_unit #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite_M (MemWrite_M),
    .MemToReg_M (MemToReg_M),
    .ANS_M      (ANS_M),
    .RD2_M      (RD2_M),
    .PC_M       (PC_M),
    .stall_M    (stall_M),
    .RD_M       (RD_M),
    .rd_valid   (rd_valid),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    MemWrite_M = 1'b0;
    MemToReg_M = 1'b0;
    ANS_M      = '0;
    RD2_M      = '0;
    PC_M       = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = '0;
    ref_rd = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  // Drives one request and follows it to completion. Leaves the inputs asserted
  // during DONE for accepted requests; drops them after one cycle for rejected ones.
  task automatic run_op(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] pc,
                        output int stalls, output logic valid, output logic [31:0] rdata,
                        output logic err_seen, output logic timed_out);
    int guard;
    @(negedge clk);
    MemWrite_M = wr;
    MemToReg_M = rd;
    ANS_M      = a;
    RD2_M      = d;
    PC_M       = pc;
    #1;
    stalls = 0; err_seen = 1'b0; timed_out = 1'b0; guard = 0; valid = 1'b0; rdata = '0;
    if (stall_M !== 1'b1) begin
      @(negedge clk);
      drive_idle();
      #1;
      err_seen = addr_err;
      valid    = rd_valid;
      rdata    = RD_M;
      return;
    end
    while (stall_M === 1'b1 && guard < 40) begin
      stalls++;
      err_seen |= addr_err;
      @(negedge clk);
      #1;
      guard++;
    end
    timed_out = (guard >= 40);
    valid     = rd_valid;
    rdata     = RD_M;
    err_seen |= addr_err;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    MemWrite_M = 1'b1;
    ANS_M = 32'h0;
    RD2_M = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (stall_M !== 1'b0) begin
        failures++; $display("FAIL reset_stall cycle %0d: got %b expected 0", c, stall_M);
      end
      checks++;
      if ({RD_M, rd_valid, addr_err} !== 34'h0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: got RD_M=%h rd_valid=%b addr_err=%b expected all 0",
                 c, RD_M, rd_valid, addr_err);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    model_clear();
    for (int w = 0; w < 4; w++) begin
      int s; logic v, e, t; logic [31:0] r;
      run_op(1'b0, 1'b1, 32'(w * 4), '0, 32'h100, s, v, r, e, t);
      checks++;
      if (v !== 1'b1 || r !== 32'h0 || s != STALLS) begin
        failures++;
        $display("FAIL reset_mem[%0d]: got valid=%b data=%h stalls=%0d expected 1/00000000/%0d",
                 w, v, r, s, STALLS);
      end
    end
  endtask

  task automatic test_store_load();
    int s; logic v, e, t; logic [31:0] r;
    apply_reset();
    run_op(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h3008, s, v, r, e, t);
    checks++;
    if (s != STALLS || t !== 1'b0) begin
      failures++; $display("FAIL store_stalls: got %0d (timeout=%b) expected %0d", s, t, STALLS);
    end
    checks++;
    if (v !== 1'b0 || e !== 1'b0) begin
      failures++; $display("FAIL store_flags: got rd_valid=%b addr_err=%b expected 0/0", v, e);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (stall_M !== 1'b0) begin
      failures++; $display("FAIL store_no_relaunch: got stall_M=%b expected 0", stall_M);
    end
    run_op(1'b0, 1'b1, 32'h10, 32'h0, 32'h300C, s, v, r, e, t);
    checks++;
    if (s != STALLS || t !== 1'b0) begin
      failures++; $display("FAIL load_stalls: got %0d (timeout=%b) expected %0d", s, t, STALLS);
    end
    checks++;
    if (v !== 1'b1 || r !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL load_data: got valid=%b data=%h expected 1/deadbeef", v, r);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (rd_valid !== 1'b0 || RD_M !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL load_pulse_hold: got rd_valid=%b RD_M=%h expected 0/deadbeef", rd_valid, RD_M);
    end
  endtask

  task automatic test_errors();
    int s; logic v, e, t; logic [31:0] r;
    logic [31:0] bad_addr [2];
    bad_addr[0] = 32'h13;
    bad_addr[1] = 32'h4000;
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      run_op(1'b0, 1'b1, bad_addr[k], '0, 32'h200, s, v, r, e, t);
      checks++;
      if (s != 0 || e !== 1'b1 || v !== 1'b0 || r !== 32'h0) begin
        failures++;
        $display("FAIL err_%h: got stalls=%0d addr_err=%b valid=%b RD_M=%h expected 0/1/0/00000000",
                 bad_addr[k], s, e, v, r);
      end
      @(negedge clk);
      #1;
      checks++;
      if (addr_err !== 1'b0 || stall_M !== 1'b0) begin
        failures++;
        $display("FAIL err_pulse_%h: got addr_err=%b stall_M=%b expected 0/0", bad_addr[k], addr_err, stall_M);
      end
    end
    run_op(1'b1, 1'b1, 32'h30, 32'h0000_A5A5, 32'h204, s, v, r, e, t);
    checks++;
    if (s != STALLS || e !== 1'b1 || v !== 1'b0) begin
      failures++;
      $display("FAIL both_ops: got stalls=%0d addr_err=%b valid=%b expected %0d/1/0", s, e, v, STALLS);
    end
    run_op(1'b0, 1'b1, 32'h30, '0, 32'h208, s, v, r, e, t);
    checks++;
    if (v !== 1'b1 || r !== 32'h0000_A5A5) begin
      failures++; $display("FAIL both_ops_stored: got valid=%b data=%h expected 1/0000a5a5", v, r);
    end
  endtask

  task automatic test_reset_mid_wait();
    int s; logic v, e, t; logic [31:0] r;
    apply_reset();
    @(negedge clk);
    MemWrite_M = 1'b1;
    ANS_M = 32'h20;
    RD2_M = 32'h1234_5678;
    PC_M = 32'h400;
    @(negedge clk);
    #1;
    checks++;
    if (stall_M !== 1'b1) begin
      failures++; $display("FAIL midwait_stall: got %b expected 1", stall_M);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (stall_M !== 1'b0) begin
      failures++; $display("FAIL midwait_reset_stall: got %b expected 0", stall_M);
    end
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    model_clear();
    #1;
    checks++;
    if (stall_M !== 1'b0 || rd_valid !== 1'b0) begin
      failures++; $display("FAIL midwait_idle: got stall_M=%b rd_valid=%b expected 0/0", stall_M, rd_valid);
    end
    run_op(1'b0, 1'b1, 32'h20, '0, 32'h404, s, v, r, e, t);
    checks++;
    if (v !== 1'b1 || r !== 32'h0) begin
      failures++; $display("FAIL midwait_cancelled: got valid=%b data=%h expected 1/00000000", v, r);
    end
  endtask

  task automatic test_back_to_back();
    int s1, s2; logic v1, e1, t1, v2, e2, t2; logic [31:0] r1, r2;
    apply_reset();
    run_op(1'b1, 1'b0, 32'h0, 32'h1, 32'h500, s1, v1, r1, e1, t1);
    run_op(1'b0, 1'b1, 32'h0, 32'h0, 32'h504, s2, v2, r2, e2, t2);
    checks++;
    if (s1 != STALLS || s2 != STALLS || t1 !== 1'b0 || t2 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stalls: got store=%0d load=%0d expected %0d each", s1, s2, STALLS);
    end
    checks++;
    if (v2 !== 1'b1 || r2 !== 32'h1) begin
      failures++; $display("FAIL b2b_data: got valid=%b data=%h expected 1/00000001", v2, r2);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 80; n++) begin
      int s, kind, where;
      logic v, e, t, wr, rd, ok;
      logic [31:0] r, a, d, exp_rd;
      int unsigned idx;
      kind  = $urandom_range(0, 9);
      where = $urandom_range(0, 9);
      wr = (kind <= 4);
      rd = (kind == 0) || (kind >= 5);
      idx = $urandom_range(0, 15);
      a = 32'(idx) << 2;
      if (where == 0) a = a | 32'($urandom_range(1, 3));
      if (where == 1) a = a | (32'($urandom_range(1, 262143)) << 14);
      d = $urandom;
      ok = (a[1:0] == 2'b00) && (a[31:14] == '0);
      run_op(wr, rd, a, d, 32'($urandom), s, v, r, e, t);
      if (!ok) begin
        ref_rd = '0;
        checks++;
        if (s != 0 || e !== 1'b1 || v !== 1'b0 || r !== 32'h0) begin
          failures++;
          $display("FAIL rand%0d_err a=%h: got stalls=%0d addr_err=%b valid=%b RD_M=%h expected 0/1/0/00000000",
                   n, a, s, e, v, r);
        end
      end else begin
        if (wr) begin
          ref_mem[idx] = d;
          exp_rd = ref_rd;
        end else begin
          exp_rd = ref_mem[idx];
          ref_rd = exp_rd;
        end
        checks++;
        if (s != STALLS || t !== 1'b0 || e !== (wr & rd) || v !== !wr || r !== exp_rd) begin
          failures++;
          $display("FAIL rand%0d_op a=%h wr=%b rd=%b: got stalls=%0d err=%b valid=%b RD_M=%h expected %0d/%b/%b/%h",
                   n, a, wr, rd, s, e, v, r, STALLS, wr & rd, !wr, exp_rd);
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        drive_idle();
      end
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_store_load();
    test_errors();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
